// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding, iteration-core modes and flag bit positions.
// ----------------------------------------------------------------------------
package alu_pkg;

   // Operation codes presented on func
   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0001;
   localparam logic [3:0] FN_CMP = 4'b0010;
   localparam logic [3:0] FN_SLL = 4'b0011;
   localparam logic [3:0] FN_SRL = 4'b0100;
   localparam logic [3:0] FN_AND = 4'b0101;
   localparam logic [3:0] FN_NOT = 4'b0110;
   localparam logic [3:0] FN_OR  = 4'b0111;
   localparam logic [3:0] FN_XOR = 4'b1000;
   localparam logic [3:0] FN_SRA = 4'b1001;
   localparam logic [3:0] FN_MUL = 4'b1010;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Operation performed by the iterative core
   typedef enum logic [1:0] {
      IT_SLL = 2'd0,
      IT_SRL = 2'd1,
      IT_SRA = 2'd2,
      IT_MUL = 2'd3
   } iter_mode_t;

   // Bit positions inside flags = {neg, pos, zero}
   localparam int FLAG_NEG  = 2;
   localparam int FLAG_POS  = 1;
   localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/alu_seq_iter_core.sv
// ----------------------------------------------------------------------------
// alu_seq_iter_core
// Iterative datapath shared by the multi-cycle shifts and the shift-add
// multiply. One iteration is performed per clock while busy; the down-counter
// is loaded with (iterations - 1) and the final iteration is flagged by
// 'last', together with the combinational value the work register takes on
// that same edge.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-low reset
//   start     in   load operands and begin iterating
//   mode      in   SLL / SRL / SRA / MUL
//   a         in   shift operand or multiplicand
//   b         in   multiplier (ignored for shifts)
//   cnt_init  in   iterations minus one
//   last      out  the current cycle performs the final iteration
//   work_next out  value of the work register after this cycle's iteration
// ----------------------------------------------------------------------------
module alu_seq_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  iter_mode_t       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   cnt_init,
   output logic             last,
   output logic [WIDTH-1:0] work_next
);

   logic                    busy_q;
   iter_mode_t              mode_q;
   logic [SHW-1:0]          cnt_q;
   logic signed [WIDTH-1:0] work_q;
   logic [WIDTH-1:0]        mcand_q;
   logic [WIDTH-1:0]        mplier_q;

   assign last = busy_q && (cnt_q == '0);

   // One iteration of the selected operation
   always_comb begin
      work_next = work_q;
      case (mode_q)
         IT_SLL:  work_next = {work_q[WIDTH-2:0], 1'b0};
         IT_SRL:  work_next = {1'b0, work_q[WIDTH-1:1]};
         IT_SRA:  work_next = work_q >>> 1;
         IT_MUL:  work_next = mplier_q[0] ? (work_q + mcand_q) : work_q;
         default: work_next = work_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q   <= 1'b0;
         mode_q   <= IT_SLL;
         cnt_q    <= '0;
         work_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         mode_q   <= mode;
         cnt_q    <= cnt_init;
         // Multiply accumulates from zero; shifts operate on the operand itself
         work_q   <= (mode == IT_MUL) ? '0 : a;
         mcand_q  <= a;
         mplier_q <= b;
      end else if (busy_q) begin
         work_q   <= work_next;
         mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
         cnt_q    <= cnt_q - SHW'(1);
         if (last) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// ----------------------------------------------------------------------------
// alu_seq_unit
// Handshaked multi-cycle ALU. Single-cycle operations are evaluated on the
// accept edge; variable shifts and the multiply run in alu_seq_iter_core.
// The result is held with out_valid until the consumer takes it.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_valid / in_ready request handshake
//   func, op_a, op_b    operation code and operands
//   shamt               shift amount for SLL/SRL/SRA
//   out_valid/out_ready result handshake
//   result              operation result
//   flags               {neg, pos, zero}
//   carry               ADD carry-out, SUB/CMP no-borrow, else 0
//   illegal             func was an unassigned code
// ----------------------------------------------------------------------------
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   output logic             carry,
   output logic             illegal
);

   function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] r);
      logic [2:0] f;
      f            = '0;
      f[FLAG_ZERO] = (r == '0);
      f[FLAG_NEG]  = r[WIDTH-1];
      f[FLAG_POS]  = !f[FLAG_ZERO] && !f[FLAG_NEG];
      return f;
   endfunction

   state_t           state_q, state_d;
   logic             accept;
   logic             is_shift, is_mul, iter_start;
   iter_mode_t       iter_mode;
   logic [SHW-1:0]   iter_cnt;
   logic             core_last;
   logic [WIDTH-1:0] core_work_next;

   logic [WIDTH:0]   sum_ext, diff_ext;
   logic [WIDTH-1:0] sc_result;
   logic [2:0]       sc_flags;
   logic             sc_carry, sc_illegal;

   logic [WIDTH-1:0] result_q;
   logic [2:0]       flags_q;
   logic             carry_q, illegal_q;

   assign accept   = in_valid && in_ready;
   assign is_shift = (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
   assign is_mul   = (func == FN_MUL);
   // A zero-amount shift completes like a single-cycle op
   assign iter_start = accept && (is_mul || (is_shift && (shamt != '0)));
   assign iter_cnt   = is_mul ? SHW'(WIDTH - 1) : (shamt - SHW'(1));

   always_comb begin
      case (func)
         FN_SLL:  iter_mode = IT_SLL;
         FN_SRL:  iter_mode = IT_SRL;
         FN_SRA:  iter_mode = IT_SRA;
         default: iter_mode = IT_MUL;
      endcase
   end

   alu_seq_iter_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (iter_start),
      .mode      (iter_mode),
      .a         (op_a),
      .b         (op_b),
      .cnt_init  (iter_cnt),
      .last      (core_last),
      .work_next (core_work_next)
   );

   // Single-cycle operations, evaluated on the accept edge
   assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
   assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      sc_result  = '0;
      sc_carry   = 1'b0;
      sc_illegal = 1'b0;
      case (func)
         FN_ADD: begin
            sc_result = sum_ext[WIDTH-1:0];
            sc_carry  = sum_ext[WIDTH];
         end
         FN_SUB, FN_CMP: begin
            sc_result = diff_ext[WIDTH-1:0];
            sc_carry  = !diff_ext[WIDTH];   // top bit set means a borrow
         end
         FN_AND: sc_result = op_a & op_b;
         FN_NOT: sc_result = ~op_a;
         FN_OR:  sc_result = op_a | op_b;
         FN_XOR: sc_result = op_a ^ op_b;
         FN_SLL, FN_SRL, FN_SRA: sc_result = op_a;
         FN_MUL: sc_result = '0;
         default: sc_illegal = 1'b1;
      endcase
      sc_flags = flags_of(sc_result);
      // CMP compares the operands directly so the answer survives overflow
      if (func == FN_CMP) begin
         sc_flags            = '0;
         sc_flags[FLAG_ZERO] = (op_a == op_b);
         sc_flags[FLAG_NEG]  = ($signed(op_a) < $signed(op_b));
         sc_flags[FLAG_POS]  = ($signed(op_a) > $signed(op_b));
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (iter_start) state_d = is_mul ? ST_MUL : ST_SHIFT;
               else            state_d = ST_DONE;
            end
         end
         ST_SHIFT, ST_MUL: if (core_last) state_d = ST_DONE;
         ST_DONE:          if (out_ready) state_d = ST_IDLE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Result registers: loaded on completion, held through backpressure
   always_ff @(posedge clk) begin
      if (!rst) begin
         result_q  <= '0;
         flags_q   <= '0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         if (iter_start) begin
            illegal_q <= 1'b0;
         end else begin
            result_q  <= sc_result;
            flags_q   <= sc_flags;
            carry_q   <= sc_carry;
            illegal_q <= sc_illegal;
         end
      end else if (core_last) begin
         result_q  <= core_work_next;
         flags_q   <= flags_of(core_work_next);
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
      end
   end

   assign result  = result_q;
   assign flags   = flags_q;
   assign carry   = carry_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  func = 4'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic [2:0]  flags;
   logic        carry;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_seq_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func      (func),
      .op_a      (op_a),
      .op_b      (op_b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .carry     (carry),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
      chk("in_ready_before_issue", in_ready, 1);
      func = f; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Cycles from accept edge until out_valid is seen; bounded
   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      if (out_valid !== 1'b1) chk("out_valid_timeout", out_valid, 1);
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_valid_after_handoff"}, out_valid, 0);
      chk({tag, "_ready_after_handoff"}, in_ready, 1);
   endtask

   task automatic run(input string tag, input logic [3:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] s, input int exp_lat,
                      input logic [31:0] exp_res, input logic [2:0] exp_flags,
                      input logic exp_carry, input logic exp_ill);
      int lat;
      issue(f, a, b, s);
      wait_valid(lat);
      chk({tag, "_lat"},     lat,     exp_lat);
      chk({tag, "_result"},  result,  exp_res);
      chk({tag, "_flags"},   flags,   exp_flags);
      chk({tag, "_carry"},   carry,   exp_carry);
      chk({tag, "_illegal"}, illegal, exp_ill);
      handoff(tag);
   endtask

   initial begin
      int lat;

      // Reset state
      rst = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result",    result,    0);
      chk("rst_flags",     flags,     0);
      chk("rst_carry",     carry,     0);
      chk("rst_illegal",   illegal,   0);
      rst = 1'b1;
      tick();

      // ADD with carry-out wrapping to zero
      run("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 32'h0, 3'b001, 1'b1, 1'b0);

      // CMP signed less-than then equality: flags never sticky
      run("cmp_lt", 4'b0010, 32'hFFFF_FFFE, 32'h3, 5'd0, 1, 32'hFFFF_FFFB, 3'b100, 1'b1, 1'b0);
      run("cmp_eq", 4'b0010, 32'h5, 32'h5, 5'd0, 1, 32'h0, 3'b001, 1'b1, 1'b0);
      // CMP across signed overflow: 0x7FFFFFFF > -1 although unsigned smaller
      run("cmp_ovf", 4'b0010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1, 32'h8000_0000, 3'b010, 1'b0, 1'b0);
      run("sub", 4'b0001, 32'h3, 32'h5, 5'd0, 1, 32'hFFFF_FFFE, 3'b100, 1'b0, 1'b0);

      // Logic ops
      run("and", 4'b0101, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1, 32'h00F0_1234, 3'b010, 1'b0, 1'b0);
      run("not", 4'b0110, 32'hFFFF_FFFF, 32'h0, 5'd0, 1, 32'h0, 3'b001, 1'b0, 1'b0);
      run("or",  4'b0111, 32'h8000_0000, 32'h1, 5'd0, 1, 32'h8000_0001, 3'b100, 1'b0, 1'b0);
      run("xor", 4'b1000, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd0, 1, 32'h5555_5555, 3'b010, 1'b0, 1'b0);

      // Shifts
      run("sra4",   4'b1001, 32'h8000_0010, 32'h0, 5'd4,  5,  32'hF800_0001, 3'b100, 1'b0, 1'b0);
      run("sll0",   4'b0011, 32'h8000_0010, 32'h0, 5'd0,  1,  32'h8000_0010, 3'b100, 1'b0, 1'b0);
      run("sll3",   4'b0011, 32'h0000_0011, 32'h0, 5'd3,  4,  32'h0000_0088, 3'b010, 1'b0, 1'b0);
      run("srl31",  4'b0100, 32'h8000_0010, 32'h0, 5'd31, 32, 32'h0000_0001, 3'b010, 1'b0, 1'b0);

      // MUL with operands changed after accept
      issue(4'b1010, 32'h0001_0003, 32'h0000_0005, 5'd0);
      op_a = 32'hDEAD_BEEF;
      op_b = 32'h1234_5678;
      wait_valid(lat);
      chk("mul_lat",    lat,    33);
      chk("mul_result", result, 32'h0005_000F);
      chk("mul_flags",  flags,  3'b010);
      chk("mul_carry",  carry,  0);
      handoff("mul");
      run("mul_max", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 33, 32'h1, 3'b010, 1'b0, 1'b0);

      // Backpressure: result held, new request refused
      issue(4'b0000, 32'd10, 32'd20, 5'd0);
      wait_valid(lat);
      chk("bp_lat", lat, 1);
      func = 4'b0001; op_a = 32'h55; op_b = 32'h1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready",  in_ready,  0);
         chk("bp_result",    result,    32'd30);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp_handoff_valid", out_valid, 0);
      chk("bp_handoff_ready", in_ready,  1);
      chk("bp_handoff_result", result,   32'd30);
      tick();
      chk("bp_no_accept_ready", in_ready, 1);
      chk("bp_no_accept_valid", out_valid, 0);

      // Reset mid-MUL aborts silently
      issue(4'b1010, 32'h3, 32'h7, 5'd0);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b0;
      tick();
      chk("rmid_in_ready",  in_ready,  1);
      chk("rmid_out_valid", out_valid, 0);
      chk("rmid_result",    result,    0);
      chk("rmid_flags",     flags,     0);
      chk("rmid_carry",     carry,     0);
      chk("rmid_illegal",   illegal,   0);
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("rmid_no_result", out_valid, 0);
      end

      // Illegal code, then cleared by next accepted request
      run("illegal", 4'b1111, 32'h1234, 32'h5678, 5'd0, 1, 32'h0, 3'b001, 1'b0, 1'b1);
      run("after_ill", 4'b0000, 32'h1, 32'h2, 5'd0, 1, 32'h3, 3'b010, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
